// File: rtl/int_req.sv
// Interrupt request block: synchronises device requests, latches rising edges as
// pending, posts the highest-priority unmasked source to the flag logic and holds off after ack.
module int_req #(
    parameter int         NSRC  = 8,
    parameter int         HOLD  = 4,
    parameter logic [7:0] VBASE = 8'o200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic            state_fetch,
    input  logic            destintmask,
    input  logic            srcintack,
    input  logic [31:0]     ob,
    output logic            sintr,
    output logic [31:0]     int_status
);

    localparam int CW = $clog2(HOLD + 1);
    localparam int SV = (NSRC < 8) ? NSRC : 8;

    typedef enum logic [1:0] {IDLE, POST, GAP} state_t;

    state_t          state, state_nx;
    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] pending, mask, edge_det, eligible, clr;
    logic [3:0]      src, win;
    logic            win_vld;
    logic [7:0]      vector;
    logic [CW-1:0]   cnt;
    logic            ack, mask_wr;

    assign ack      = state_fetch & srcintack;
    assign mask_wr  = state_fetch & destintmask;
    assign edge_det = s2 & ~s3;
    assign eligible = pending & ~mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Scan downwards so the lowest set index is the last one written and wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win     = 4'(i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        clr      = '0;
        case (state)
            IDLE: if (win_vld) state_nx = POST;
            POST: begin
                if (ack) begin
                    state_nx = GAP;
                    clr      = NSRC'(1) << src;
                end
            end
            GAP:  if (cnt == CW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The vector and source latch only on entry to POST, so later arrivals or mask
    // writes cannot disturb a request the CPU is already servicing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
            mask    <= '0;
            src     <= '0;
            vector  <= '0;
            cnt     <= '0;
            sintr   <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= (pending & ~clr) | edge_det;
            sintr   <= (state_nx == POST);
            if (mask_wr)
                mask <= ob[NSRC-1:0];
            if (state == IDLE && win_vld) begin
                src    <= win;
                vector <= VBASE + {4'b0, win};
            end
            if (state == POST && ack)
                cnt <= CW'(HOLD);
            else if (state == GAP)
                cnt <= cnt - CW'(1);
        end
    end

    assign int_status = {sintr, 7'b0, 8'(pending[SV-1:0]), 8'(mask[SV-1:0]), vector};

endmodule
